dmem_responder: RTL and testbench

Memory-side responder for the load/store unit. It accepts one LSU memory request at a time over a valid/ready handshake and executes it against an on-chip synchronous data RAM. Supported operations are loads, stores, LR/SC and a subset of AMOs. It returns load/old-value data, or a fault, over a valid/ready response channel. The block sits between the LSU stage and the FPGA block RAM, replacing the LSU's pass-through data path.

---
 rtl/mem_pkg.sv | 59 +++++
 rtl/dmem_bram.sv | 23 ++
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the data-memory responder: op/size encodings,
// fault codes, and byte-enable / lane-extract functions.
package mem_pkg;

    typedef enum logic [3:0] {
        OP_LD      = 4'd0,
        OP_ST      = 4'd1,
        OP_LR      = 4'd2,
        OP_SC      = 4'd3,
        OP_AMOSWAP = 4'd4,
        OP_AMOADD  = 4'd5,
        OP_AMOAND  = 4'd6,
        OP_AMOOR   = 4'd7,
        OP_AMOXOR  = 4'd8
    } mem_req_op_t;

    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} mem_size_t;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} dmem_state_t;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_ACCESS   = 2'd2;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'd3;

    function automatic logic [7:0] byte_en(mem_size_t size, logic [2:0] off);
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

    function automatic logic misaligned(mem_size_t size, logic [2:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

    // Pull the addressed lane down to bit 0 and zero/sign-extend it to 64 bits.
    function automatic logic [63:0] lane_extract(logic [63:0] word, mem_size_t size,
                                                 logic [2:0] off, logic sgn);
        logic [63:0] s;
        s = word >> {off, 3'b000};
        case (size)
            SZ_B:    return sgn ? {{56{s[7]}},  s[7:0]}  : {56'd0, s[7:0]};
            SZ_H:    return sgn ? {{48{s[15]}}, s[15:0]} : {48'd0, s[15:0]};
            SZ_W:    return sgn ? {{32{s[31]}}, s[31:0]} : {32'd0, s[31:0]};
            default: return s;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port 64-bit data RAM with per-byte write enables and a registered
// (read-first) read port, written so FPGA tools map it onto block RAM.
module dmem_bram #(
    parameter int DEPTH = 4096,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             we,
    input  logic [7:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [63:0]      wdata,
    output logic [63:0]      rdata
);

    logic [7:0][7:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 8; b++)
            if (we && be[b]) mem[idx][b] <= wdata[b*8 +: 8];
        rdata <= mem[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: runs one LSU request (load/store/LR/SC/AMO) at a time
// against the on-chip data RAM and returns data or a fault code.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [3:0]  i_req_op,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_signed,
    input  logic [63:0] i_req_addr,
    input  logic [63:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [63:0] o_resp_data,
    output logic [1:0]  o_resp_fault
);

    dmem_state_t state, state_d;
    mem_req_op_t op_q;
    mem_size_t   size_q;
    logic        sgn_q;
    logic [63:0] addr_q, wdata_q, wr_word_q, resp_data;
    logic [7:0]  be_q;
    logic [1:0]  resp_fault, req_fault;
    logic        resv_valid;
    logic [60:0] resv_addr;

    logic [IDX_W-1:0] ram_idx;
    logic             ram_we;
    logic [63:0]      ram_rdata, old_ext, amo_res, shifted, merged;
    logic [7:0]       be;
    logic             hit, accept;

    dmem_bram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_bram (
        .i_clk (i_clk),
        .we    (ram_we),
        .be    (be_q),
        .idx   (ram_idx),
        .wdata (wr_word_q),
        .rdata (ram_rdata)
    );

    // Request-side fault classification, highest priority first.
    always_comb begin
        req_fault = FAULT_NONE;
        if (i_req_op > 4'd8)
            req_fault = FAULT_ILLEGAL;
        else if (i_req_op >= 4'd2 && i_req_size < 2'd2)
            req_fault = FAULT_ILLEGAL;
        else if (misaligned(mem_size_t'(i_req_size), i_req_addr[2:0]))
            req_fault = FAULT_MISALIGN;
        else if (|(i_req_addr >> (IDX_W + 3)))
            req_fault = FAULT_ACCESS;
    end

    // Read-stage datapath: old lane value, AMO result, and the merged write word.
    always_comb begin
        old_ext = lane_extract(ram_rdata, size_q, addr_q[2:0], sgn_q || (op_q != OP_LD));
        case (op_q)
            OP_AMOADD: amo_res = old_ext + wdata_q;
            OP_AMOAND: amo_res = old_ext & wdata_q;
            OP_AMOOR:  amo_res = old_ext | wdata_q;
            OP_AMOXOR: amo_res = old_ext ^ wdata_q;
            default:   amo_res = wdata_q;
        endcase
        shifted = amo_res << {addr_q[2:0], 3'b000};
        be      = byte_en(size_q, addr_q[2:0]);
        merged  = ram_rdata;
        for (int b = 0; b < 8; b++)
            if (be[b]) merged[b*8 +: 8] = shifted[b*8 +: 8];
        hit = resv_valid && (resv_addr == addr_q[63:3]);
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        ram_idx = (state == S_IDLE) ? i_req_addr[IDX_W+2:3] : addr_q[IDX_W+2:3];
        // A write landing on the reset edge is dropped.
        ram_we  = (state == S_WRITE) && i_rst_n;
        case (state)
            S_IDLE: if (i_req_valid && !i_flush) begin
                accept  = 1'b1;
                state_d = (req_fault != FAULT_NONE) ? S_RESP : S_READ;
            end
            S_READ: begin
                if (i_flush)
                    state_d = S_IDLE;
                else if (op_q == OP_LD || op_q == OP_LR || (op_q == OP_SC && !hit))
                    state_d = S_RESP;
                else
                    state_d = S_WRITE;
            end
            S_WRITE: state_d = i_flush ? S_IDLE : S_RESP;
            S_RESP:  if (i_flush || i_resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            resp_data  <= '0;
            resp_fault <= FAULT_NONE;
            resv_valid <= 1'b0;
        end else begin
            state <= state_d;
            if (state == S_IDLE && accept) begin
                op_q       <= mem_req_op_t'(i_req_op);
                size_q     <= mem_size_t'(i_req_size);
                sgn_q      <= i_req_signed;
                addr_q     <= i_req_addr;
                wdata_q    <= i_req_wdata;
                resp_fault <= req_fault;
                resp_data  <= '0;
            end
            if (state == S_READ && !i_flush) begin
                wr_word_q <= merged;
                be_q      <= be;
                case (op_q)
                    OP_LD: resp_data <= old_ext;
                    OP_LR: begin
                        resp_data  <= old_ext;
                        resv_valid <= 1'b1;
                        resv_addr  <= addr_q[63:3];
                    end
                    OP_SC: begin
                        resv_valid <= 1'b0;
                        resp_data  <= hit ? 64'd0 : 64'd1;
                    end
                    default: begin
                        if (hit) resv_valid <= 1'b0;
                        resp_data <= (op_q == OP_ST) ? 64'd0 : old_ext;
                    end
                endcase
            end
        end
    end

    assign o_req_ready  = (state == S_IDLE);
    assign o_resp_valid = (state == S_RESP);
    assign o_resp_data  = resp_data;
    assign o_resp_fault = resp_fault;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table of requests with hand-computed
// responses and latencies, plus sequences for backpressure, flush and mid-write reset.
module tb_dmem_responder;
    import mem_pkg::*;

    logic        i_clk = 0, i_rst_n = 0, i_flush = 0, i_req_valid = 0, i_req_signed = 0;
    logic        i_resp_ready = 1;
    logic [3:0]  i_req_op = 0;
    logic [1:0]  i_req_size = 0;
    logic [63:0] i_req_addr = 0, i_req_wdata = 0;
    logic        o_req_ready, o_resp_valid;
    logic [63:0] o_resp_data;
    logic [1:0]  o_resp_fault;

    int errors = 0, checks = 0;

    dmem_responder dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_op(i_req_op), .i_req_size(i_req_size), .i_req_signed(i_req_signed),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_resp_data(o_resp_data), .o_resp_fault(o_resp_fault)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [1:0]  size;
        logic        sgn;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_data;
        logic [1:0]  exp_fault;
        int          exp_lat;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string n, input logic [3:0] op, input logic [1:0] sz, input logic sg,
                       input logic [63:0] a, input logic [63:0] wd, input logic [63:0] ed,
                       input logic [1:0] ef, input int el);
        vec_t v;
        v.name = n; v.op = op; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd;
        v.exp_data = ed; v.exp_fault = ef; v.exp_lat = el;
        tbl.push_back(v);
    endtask

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Present one request, wait for o_resp_valid (bounded), report data/fault/latency.
    task automatic do_req(input logic [3:0] op, input logic [1:0] sz, input logic sg,
                          input logic [63:0] a, input logic [63:0] wd,
                          output logic [63:0] d, output logic [1:0] f, output int lat);
        @(negedge i_clk);
        i_req_valid = 1; i_req_op = op; i_req_size = sz; i_req_signed = sg;
        i_req_addr = a; i_req_wdata = wd;
        @(posedge i_clk); #1;
        i_req_valid = 0;
        lat = 1;
        while (!o_resp_valid && lat < 20) begin
            @(posedge i_clk); #1;
            lat++;
        end
        if (!o_resp_valid) begin
            errors++;
            $display("FAIL resp_timeout: got no response expected o_resp_valid within 20 cycles");
        end
        d = o_resp_data;
        f = o_resp_fault;
    endtask

    task automatic consume();
        i_resp_ready = 1;
        @(posedge i_clk); #1;
    endtask

    logic [63:0] d, held;
    logic [1:0]  f;
    int          lat;

    initial begin
        add("st_d_100",    OP_ST,  SZ_D, 0, 64'h100, 64'h1122334455667788, 64'h0, 0, 3);
        add("ld_b_107",    OP_LD,  SZ_B, 1, 64'h107, 0, 64'h11, 0, 2);
        add("ld_h_106",    OP_LD,  SZ_H, 1, 64'h106, 0, 64'h1122, 0, 2);
        add("st_w_104",    OP_ST,  SZ_W, 0, 64'h104, 64'h80000000, 64'h0, 0, 3);
        add("ld_w_104_s",  OP_LD,  SZ_W, 1, 64'h104, 0, 64'hFFFFFFFF80000000, 0, 2);
        add("ld_w_104_u",  OP_LD,  SZ_W, 0, 64'h104, 0, 64'h0000000080000000, 0, 2);
        add("ld_w_100_u",  OP_LD,  SZ_W, 0, 64'h100, 0, 64'h55667788, 0, 2);
        add("st_w_200",    OP_ST,  SZ_W, 0, 64'h200, 64'h7FFFFFFF, 64'h0, 0, 3);
        add("amoadd_w",    OP_AMOADD, SZ_W, 0, 64'h200, 64'h1, 64'h7FFFFFFF, 0, 3);
        add("ld_w_200_s",  OP_LD,  SZ_W, 1, 64'h200, 0, 64'hFFFFFFFF80000000, 0, 2);
        add("amoor_w",     OP_AMOOR, SZ_W, 0, 64'h200, 64'hF, 64'hFFFFFFFF80000000, 0, 3);
        add("ld_w_200_u",  OP_LD,  SZ_W, 0, 64'h200, 0, 64'h8000000F, 0, 2);
        add("st_d_300",    OP_ST,  SZ_D, 0, 64'h300, 64'h0, 64'h0, 0, 3);
        add("lr_d_300",    OP_LR,  SZ_D, 0, 64'h300, 0, 64'h0, 0, 2);
        add("sc_ok",       OP_SC,  SZ_D, 0, 64'h300, 64'hAB, 64'h0, 0, 3);
        add("ld_after_sc", OP_LD,  SZ_D, 0, 64'h300, 0, 64'hAB, 0, 2);
        add("sc_again",    OP_SC,  SZ_D, 0, 64'h300, 64'hCD, 64'h1, 0, 2);
        add("ld_sc_fail",  OP_LD,  SZ_D, 0, 64'h300, 0, 64'hAB, 0, 2);
        add("lr_d_300_b",  OP_LR,  SZ_D, 0, 64'h300, 0, 64'hAB, 0, 2);
        add("st_kill_rsv", OP_ST,  SZ_D, 0, 64'h300, 64'h55, 64'h0, 0, 3);
        add("sc_after_st", OP_SC,  SZ_D, 0, 64'h300, 64'h77, 64'h1, 0, 2);
        add("ld_300_fin",  OP_LD,  SZ_D, 0, 64'h300, 0, 64'h55, 0, 2);
        add("misalign",    OP_LD,  SZ_H, 0, 64'h101, 0, 64'h0, 1, 1);
        add("out_range",   OP_LD,  SZ_D, 0, 64'h8000, 0, 64'h0, 2, 1);
        add("illegal_op",  4'd15,  SZ_D, 0, 64'h100, 64'hFF, 64'h0, 3, 1);
        add("amo_byte",    OP_AMOSWAP, SZ_B, 0, 64'h100, 64'hEE, 64'h0, 3, 1);
        add("ld_d_100",    OP_LD,  SZ_D, 0, 64'h100, 0, 64'h8000000055667788, 0, 2);

        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_resp_valid", {63'd0, o_resp_valid}, 64'd0);
        chk("rst_resp_data",  o_resp_data, 64'd0);
        chk("rst_resp_fault", {62'd0, o_resp_fault}, 64'd0);
        @(negedge i_clk);
        i_rst_n = 1;
        #1;
        chk("rst_req_ready",  {63'd0, o_req_ready}, 64'd1);

        foreach (tbl[i]) begin
            do_req(tbl[i].op, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, d, f, lat);
            chk({tbl[i].name, ".data"},  d, tbl[i].exp_data);
            chk({tbl[i].name, ".fault"}, {62'd0, f}, {62'd0, tbl[i].exp_fault});
            chk({tbl[i].name, ".lat"},   64'(lat), 64'(tbl[i].exp_lat));
            consume();
        end

        // Backpressure: response must hold for 5 cycles with ready low.
        i_resp_ready = 0;
        do_req(OP_LD, SZ_W, 1, 64'h104, 0, held, f, lat);
        chk("hold.data0", held, 64'hFFFFFFFF80000000);
        for (int c = 0; c < 5; c++) begin
            @(posedge i_clk); #1;
            chk("hold.stable", {o_resp_valid, o_req_ready, o_resp_data},
                {1'b1, 1'b0, held});
        end
        consume();
        chk("hold.release", {62'd0, o_req_ready, o_resp_valid}, 64'b10);

        // Flush while the store is in READ: nothing written, no response.
        @(negedge i_clk);
        i_req_valid = 1; i_req_op = OP_ST; i_req_size = SZ_D; i_req_addr = 64'h100;
        i_req_wdata = 64'hDEADBEEFDEADBEEF;
        @(posedge i_clk); #1;
        i_req_valid = 0; i_flush = 1;
        @(posedge i_clk); #1;
        i_flush = 0;
        chk("flush_rd.idle", {62'd0, o_req_ready, o_resp_valid}, 64'b10);
        do_req(OP_LD, SZ_D, 0, 64'h100, 0, d, f, lat);
        chk("flush_rd.old", d, 64'h8000000055667788);
        consume();

        // Flush while a response is pending drops it.
        i_resp_ready = 0;
        do_req(OP_LD, SZ_D, 0, 64'h300, 0, d, f, lat);
        i_flush = 1;
        @(posedge i_clk); #1;
        i_flush = 0;
        i_resp_ready = 1;
        chk("flush_resp.drop", {62'd0, o_req_ready, o_resp_valid}, 64'b10);

        // Reset landing while the store is in WRITE: write dropped, outputs cleared.
        @(negedge i_clk);
        i_req_valid = 1; i_req_op = OP_ST; i_req_size = SZ_D; i_req_addr = 64'h100;
        i_req_wdata = 64'hCAFEF00DCAFEF00D;
        @(posedge i_clk); #1;
        i_req_valid = 0;
        @(posedge i_clk); #1;
        i_rst_n = 0;
        @(posedge i_clk); #1;
        chk("rst_wr.outs", {o_req_ready, o_resp_valid, o_resp_fault, o_resp_data[59:0]},
            {1'b1, 1'b0, 2'b00, 60'd0});
        chk("rst_wr.data", o_resp_data, 64'd0);
        @(negedge i_clk);
        i_rst_n = 1;
        do_req(OP_LD, SZ_D, 0, 64'h100, 0, d, f, lat);
        chk("rst_wr.nowrite", d, 64'h8000000055667788);
        consume();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
